mc_ctrl_unit: RTL

// - Multicycle control FSM for the processor datapath: sequences fetch, decode, execute and writeback.
// - Holds the NZCV flags register and evaluates the instruction condition field against it.
// - Gates every architectural write (register file, memory, PC) with the condition result.
// - Sits between the instruction register / ALU and the datapath mux selects and write enables.

---
 rtl/mc_ctrl_pkg.sv | 67 ++++++
 rtl/cond_eval.sv | 38 +++
 rtl/mc_ctrl_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, condition
// codes, instruction op classes, data-processing commands and ALU controls.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXER   = 4'd6,
    S_EXEI   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  // Condition field encodings
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Instruction classes (Instr[27:26])
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  // Data-processing commands (funct[4:1])
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // ALU operation select
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Unknown commands fall back to ADD
  function automatic logic [1:0] cmd_to_alu(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD: cmd_to_alu = ALU_ADD;
      CMD_SUB: cmd_to_alu = ALU_SUB;
      CMD_CMP: cmd_to_alu = ALU_SUB;
      CMD_AND: cmd_to_alu = ALU_AND;
      CMD_ORR: cmd_to_alu = ALU_ORR;
      default: cmd_to_alu = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Condition-field evaluator: decides whether an instruction executes given
// the registered NZCV flags. Purely combinational.
module cond_eval
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_pass
);

  logic w_n, w_z, w_c, w_v;
  assign {w_n, w_z, w_c, w_v} = i_flags;

  // Map each condition code to its flag predicate
  always_comb begin
    o_pass = 1'b0;
    case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = ~w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = ~w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = ~w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = ~w_v;
      COND_HI: o_pass = w_c & ~w_z;
      COND_LS: o_pass = ~w_c | w_z;
      COND_GE: o_pass = ~(w_n ^ w_v);
      COND_LT: o_pass = w_n ^ w_v;
      COND_GT: o_pass = ~w_z & ~(w_n ^ w_v);
      COND_LE: o_pass = w_z | (w_n ^ w_v);
      COND_AL: o_pass = 1'b1;
      COND_NV: o_pass = 1'b0;
      default: o_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multicycle control unit: sequences fetch/decode/execute/writeback, holds
// the NZCV flags and gates architectural writes with the condition result.
// Datapath controls are a Moore decode of the state register; they are held
// at zero combinationally while rst_n is low so a pending write dies at once.
module mc_ctrl_unit
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_ctrl,
  output logic [3:0] flags_q,
  output logic [3:0] state_o
);

  state_t     r_state;
  logic [3:0] r_flags;
  logic       r_cond_pass;
  logic       w_cond_pass;
  logic       w_ibit, w_sbit;
  logic [3:0] w_cmd;
  logic       w_is_cmp, w_cv_upd, w_pc_dest;

  assign w_ibit    = funct[5];
  assign w_cmd     = funct[4:1];
  assign w_sbit    = funct[0];
  assign w_is_cmp  = (w_cmd == CMD_CMP);
  assign w_cv_upd  = (w_cmd == CMD_ADD) | (w_cmd == CMD_SUB) | w_is_cmp;
  assign w_pc_dest = (rd == 4'd15);

  cond_eval u_cond_eval (
    .i_cond  (cond),
    .i_flags (r_flags),
    .o_pass  (w_cond_pass)
  );

  // State register with next-state selection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_MEM:  r_state <= S_MEMADR;
            OP_DP:   r_state <= w_ibit ? S_EXEI : S_EXER;
            OP_BR:   r_state <= S_BRANCH;
            OP_ILL:  r_state <= S_FETCH;
            default: r_state <= S_FETCH;
          endcase
        end
        S_MEMADR: r_state <= w_sbit ? S_MEMRD : S_MEMWR;
        S_MEMRD:  r_state <= S_MEMWB;
        S_EXER:   r_state <= S_ALUWB;
        S_EXEI:   r_state <= S_ALUWB;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Latch the condition result as decode completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cond_pass <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_cond_pass <= w_cond_pass;
    end
  end

  // Flags update at the end of execute; C/V only for arithmetic commands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 4'b0000;
    end else if ((r_state == S_EXER || r_state == S_EXEI) && r_cond_pass &&
                 (w_sbit || w_is_cmp)) begin
      r_flags[3:2] <= alu_flags[3:2];
      if (w_cv_upd) r_flags[1:0] <= alu_flags[1:0];
    end
  end

  // Moore output decode, forced to zero while reset is asserted
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    alu_ctrl   = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_MEMADR: alu_src_b = 2'b01;
      S_MEMRD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = r_cond_pass & ~w_pc_dest;
        pc_write   = r_cond_pass & w_pc_dest;
      end
      S_MEMWR:  mem_write = r_cond_pass;
      S_EXER:   alu_ctrl = cmd_to_alu(w_cmd);
      S_EXEI: begin
        alu_src_b = 2'b01;
        alu_ctrl  = cmd_to_alu(w_cmd);
      end
      S_ALUWB: begin
        reg_write = r_cond_pass & ~w_is_cmp & ~w_pc_dest;
        pc_write  = r_cond_pass & ~w_is_cmp & w_pc_dest;
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = r_cond_pass;
      end
      default: ;
    endcase
    if (!rst_n) begin
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      result_src = 2'b00;
      alu_ctrl   = ALU_ADD;
    end
  end

  assign flags_q = r_flags;
  assign state_o = r_state;

endmodule
